if_stage: RTL and testbench

Instruction-fetch stage of the rv32 pipeline, sitting directly upstream of the instruction memory.
- Owns the program counter and drives the imem word address each cycle.
- Captures the returned instruction (combinational imem read, same cycle) into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later stages, and detects misaligned redirect targets.

---
 rtl/rv32_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 40 ++++
 rtl/if_stage.sv | 119 +++++++++++
 tb/tb_if_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline definitions: NOP encoding, data width and fetch-state encoding.
// Used by the fetch stage, the decode stage and the hazard unit.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_t;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/inst/pc with hold and clear.
// Clear drops valid but keeps inst/pc, so consumers must gate on valid.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_hold,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_inst  <= RV32_NOP;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/if_stage.sv
// rv32 instruction-fetch stage: owns the PC, drives the imem word address and fills IF/ID.
// Handles stall, flush, redirect and parks in S_FAULT on a misaligned redirect target.
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    output logic [31:0] o_if_inst,
    output logic [31:0] o_if_pc,
    output logic        o_fault,
    output logic [31:0] o_fault_pc
);

    if (!is_word_aligned(RESET_PC)) begin : g_bad_reset_pc
        $error("if_stage: RESET_PC must be 4-byte aligned");
    end
    if (IMEM_AW < 1 || IMEM_AW > 30) begin : g_bad_imem_aw
        $error("if_stage: IMEM_AW out of range");
    end

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_fault;
    logic [XLEN-1:0] r_fault_pc;

    logic            w_target_ok;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_id_clear;
    logic            w_id_hold;

    assign w_target_ok = is_word_aligned(i_redirect_pc);
    assign w_pc_inc    = r_pc + 32'd4;

    // Upper address bits pass through; imem ignores bits above IMEM_AW.
    assign o_imem_addr = {2'b00, r_pc[31:2]};

    always_comb begin
        w_id_clear = 1'b0;
        w_id_hold  = 1'b0;
        if (r_state == S_FAULT) begin
            w_id_clear = 1'b1;
        end else begin
            w_id_clear = i_redirect | i_flush;
            w_id_hold  = i_stall;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            case (r_state)
                S_BOOT, S_RUN: begin
                    if (i_redirect) begin
                        if (w_target_ok) begin
                            r_pc    <= i_redirect_pc;
                            r_state <= S_RUN;
                        end else begin
                            r_state    <= S_FAULT;
                            r_fault    <= 1'b1;
                            r_fault_pc <= i_redirect_pc;
                        end
                    end else if (i_flush) begin
                        if (!i_stall) r_pc <= w_pc_inc;
                        r_state <= S_RUN;
                    end else if (!i_stall) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_RUN;
                    end
                end
                S_FAULT: begin
                    // Only a redirect gets out; a further misaligned one just updates the reported target.
                    if (i_redirect) begin
                        if (w_target_ok) begin
                            r_pc    <= i_redirect_pc;
                            r_fault <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            r_fault_pc <= i_redirect_pc;
                        end
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_pc    <= RESET_PC;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_hold  (w_id_hold),
        .i_clear (w_id_clear),
        .i_inst  (i_imem_data),
        .i_pc    (r_pc),
        .o_valid (o_if_valid),
        .o_inst  (o_if_inst),
        .o_pc    (o_if_pc)
    );

    assign o_fault    = r_fault;
    assign o_fault_pc = r_fault_pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; imem returns 32'hA500_0000 + word address.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int total = 0;
    int bad   = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (10)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_addr   (imem_addr),
        .i_imem_data   (imem_data),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_if_valid    (if_valid),
        .o_if_inst     (if_inst),
        .o_if_pc       (if_pc),
        .o_fault       (fault),
        .o_fault_pc    (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = 32'hA500_0000 + imem_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic [31:0] addr);
        check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        check({tag, ".inst"}, if_inst, inst);
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic check_fault(input string tag, input logic f, input logic [31:0] fpc);
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
        check({tag, ".fault_pc"}, fault_pc, fpc);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        check_if("reset", 1'b0, 32'h0000_0013, 32'h0, 32'h0);
        check_fault("reset", 1'b0, 32'h0);

        // Boot: first edge after release captures A0.
        rst = 1'b0;
        check("boot.addr", imem_addr, 32'h0);
        check("boot.valid", {31'd0, if_valid}, 32'd0);
        tick(); check_if("a0", 1'b1, 32'hA500_0000, 32'h0, 32'h1);
        tick(); check_if("a1", 1'b1, 32'hA500_0001, 32'h4, 32'h2);
        tick(); check_if("a2", 1'b1, 32'hA500_0002, 32'h8, 32'h3);

        // Three stalled cycles hold everything.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_if("stall", 1'b1, 32'hA500_0002, 32'h8, 32'h3);
        end
        stall = 1'b0;
        tick(); check_if("a3", 1'b1, 32'hA500_0003, 32'hC, 32'h4);

        // Flush at pc 0x10 drops that instruction.
        flush = 1'b1;
        tick(); check_if("flush", 1'b0, 32'hA500_0003, 32'hC, 32'h5);
        flush = 1'b0;
        tick(); check_if("post_flush", 1'b1, 32'hA500_0005, 32'h14, 32'h6);

        // Redirect overrides stall.
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick(); check_if("redir", 1'b0, 32'hA500_0005, 32'h14, 32'h10);
        redirect = 1'b0; stall = 1'b0;
        tick(); check_if("redir_tgt", 1'b1, 32'hA500_0010, 32'h40, 32'h11);

        // Stall together with flush: valid cleared, pc held.
        stall = 1'b1; flush = 1'b1;
        tick(); check_if("stall_flush", 1'b0, 32'hA500_0010, 32'h40, 32'h11);
        stall = 1'b0; flush = 1'b0;
        tick(); check_if("after_sf", 1'b1, 32'hA500_0011, 32'h44, 32'h12);

        // PC wraps from 0xFFFF_FFFC to 0 without a fault.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); check_if("wrap_redir", 1'b0, 32'hA500_0011, 32'h44, 32'h3FFF_FFFF);
        redirect = 1'b0;
        tick(); check_if("wrap_top", 1'b1, 32'hE4FF_FFFF, 32'hFFFF_FFFC, 32'h0);
        tick(); check_if("wrap_zero", 1'b1, 32'hA500_0000, 32'h0, 32'h1);
        check_fault("wrap", 1'b0, 32'h0);

        // Misaligned redirect faults; stall and flush are ignored while faulted.
        redirect = 1'b1; redirect_pc = 32'h42;
        tick(); check_if("fault_in", 1'b0, 32'hA500_0000, 32'h0, 32'h1);
        check_fault("fault_in", 1'b1, 32'h42);
        redirect = 1'b0; stall = 1'b1; flush = 1'b1;
        tick(); check_if("fault_sf", 1'b0, 32'hA500_0000, 32'h0, 32'h1);
        check_fault("fault_sf", 1'b1, 32'h42);
        stall = 1'b0; flush = 1'b0;
        tick(); check_if("fault_idle", 1'b0, 32'hA500_0000, 32'h0, 32'h1);
        check_fault("fault_idle", 1'b1, 32'h42);
        redirect = 1'b1; redirect_pc = 32'h80;
        tick(); check_if("fault_exit", 1'b0, 32'hA500_0000, 32'h0, 32'h20);
        check_fault("fault_exit", 1'b0, 32'h42);
        redirect = 1'b0;
        tick(); check_if("resume", 1'b1, 32'hA500_0020, 32'h80, 32'h21);

        // Reset in S_FAULT with a redirect pending restores reset state.
        redirect = 1'b1; redirect_pc = 32'h42;
        tick(); check_fault("fault2", 1'b1, 32'h42);
        redirect_pc = 32'h100; rst = 1'b1;
        tick(); check_if("rst_fault", 1'b0, 32'h0000_0013, 32'h0, 32'h0);
        check_fault("rst_fault", 1'b0, 32'h0);
        rst = 1'b0; redirect = 1'b0;
        tick(); check_if("restart", 1'b1, 32'hA500_0000, 32'h0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
